// File: rtl/adxl362_pkg.sv
// ---------------------------------------------------------------------------
// adxl362_pkg
// Shared definitions for the ADXL362 register-transaction sequencer:
//   - SPI command opcodes and commonly used register addresses/codes
//   - controller FSM state encoding
//   - helper that picks the byte to send for a given position in the frame
// ---------------------------------------------------------------------------
package adxl362_pkg;

    // SPI command opcodes (first byte of every frame)
    localparam logic [7:0] CMD_WRITE       = 8'h0A;
    localparam logic [7:0] CMD_READ        = 8'h0B;
    localparam logic [7:0] CMD_FIFO        = 8'h0D;

    // Register map entries used by the surrounding design
    localparam logic [7:0] REG_DEVID_AD    = 8'h00;
    localparam logic [7:0] REG_PARTID      = 8'h02;
    localparam logic [7:0] REG_STATUS      = 8'h0B;
    localparam logic [7:0] REG_SOFT_RESET  = 8'h1F;
    localparam logic [7:0] SOFT_RESET_CODE = 8'h52;

    // Number of the last byte in a frame (cmd=0, addr=1, data=2)
    localparam logic [1:0] LAST_BYTE       = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_FINISH,
        ST_ABORT
    } ctrl_state_t;

    // Byte transmitted at position idx of a cmd/addr/data frame. Reads clock
    // out a dummy 0x00 in the data slot while the sensor drives MISO.
    function automatic logic [7:0] frame_byte(
        input logic [1:0] idx,
        input logic       is_write,
        input logic [7:0] reg_addr,
        input logic [7:0] reg_data
    );
        logic [7:0] b;
        case (idx)
            2'd0:    b = is_write ? CMD_WRITE : CMD_READ;
            2'd1:    b = reg_addr;
            2'd2:    b = is_write ? reg_data : 8'h00;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/adxl362_controller.sv
// ---------------------------------------------------------------------------
// adxl362_controller
// Turns a single register read/write request into a 3-byte SPI frame
// (cmd, addr, data) driven through a byte-level SPI master, keeping CS low
// across the whole frame, and returns the byte read back.
//
// Ports
//   clk, rst        system clock; asynchronous active-high reset
//   start_read      1-cycle request: read register at addr
//   start_write     1-cycle request: write wr_data to register at addr
//   addr, wr_data   request operands, captured when the request is accepted
//   busy            high from the cycle after acceptance through done/error
//   done / error    1-cycle completion / timeout-abort pulses
//   rd_data         last byte read; held until the next successful read
//   spi_start       1-cycle pulse telling the SPI master to send spi_tx_byte
//   spi_tx_byte     byte for the SPI master, held stable while it is busy
//   spi_hold_cs     asks the SPI master to keep CS low after the current byte
//   spi_busy        SPI master byte in progress
//   spi_done        SPI master 1-cycle pulse: byte finished, spi_rx_byte valid
//   spi_rx_byte     byte received on MISO for the finished byte
// ---------------------------------------------------------------------------
module adxl362_controller
    import adxl362_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_read,
    input  logic       start_write,
    input  logic [7:0] addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] rd_data,
    output logic       spi_start,
    output logic [7:0] spi_tx_byte,
    output logic       spi_hold_cs,
    input  logic       spi_busy,
    input  logic       spi_done,
    input  logic [7:0] spi_rx_byte
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    ctrl_state_t   r_state,    w_state_next;
    logic [1:0]    r_cnt,      w_cnt_next;
    logic [TW-1:0] r_tmo,      w_tmo_next;
    logic          r_is_write, w_is_write_next;
    logic [7:0]    r_addr,     w_addr_next;
    logic [7:0]    r_wr_data,  w_wr_data_next;
    logic [7:0]    r_rd_data,  w_rd_data_next;
    logic [7:0]    r_tx_byte,  w_tx_byte_next;

    logic [TW-1:0] w_tmo_inc;
    logic [1:0]    w_cnt_inc;

    assign w_tmo_inc   = r_tmo + TW'(1);
    assign w_cnt_inc   = r_cnt + 2'd1;
    assign rd_data     = r_rd_data;
    assign spi_tx_byte = r_tx_byte;

    // NOTE: state is updated with non-blocking assignments so every register
    // in this block samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 2'd0;
            r_tmo      <= '0;
            r_is_write <= 1'b0;
            r_addr     <= 8'h00;
            r_wr_data  <= 8'h00;
            r_rd_data  <= 8'h00;
            r_tx_byte  <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_tmo      <= w_tmo_next;
            r_is_write <= w_is_write_next;
            r_addr     <= w_addr_next;
            r_wr_data  <= w_wr_data_next;
            r_rd_data  <= w_rd_data_next;
            r_tx_byte  <= w_tx_byte_next;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_tmo_next      = r_tmo;
        w_is_write_next = r_is_write;
        w_addr_next     = r_addr;
        w_wr_data_next  = r_wr_data;
        w_rd_data_next  = r_rd_data;
        w_tx_byte_next  = r_tx_byte;
        busy            = 1'b0;
        done            = 1'b0;
        error           = 1'b0;
        spi_start       = 1'b0;
        spi_hold_cs     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Write wins when both requests arrive together.
                if ((start_write || start_read) && !spi_busy) begin
                    w_is_write_next = start_write;
                    w_addr_next     = addr;
                    w_wr_data_next  = wr_data;
                    w_cnt_next      = 2'd0;
                    w_tx_byte_next  = frame_byte(2'd0, start_write, addr, wr_data);
                    w_state_next    = ST_SEND;
                end
            end

            ST_SEND: begin
                busy         = 1'b1;
                spi_start    = 1'b1;
                spi_hold_cs  = (r_cnt != LAST_BYTE);
                w_tmo_next   = '0;
                w_state_next = ST_WAIT;
            end

            ST_WAIT: begin
                busy        = 1'b1;
                spi_hold_cs = (r_cnt != LAST_BYTE);
                // A byte completing on the deadline cycle still counts.
                if (spi_done) begin
                    if (r_cnt != LAST_BYTE) begin
                        w_cnt_next     = w_cnt_inc;
                        w_tx_byte_next = frame_byte(w_cnt_inc, r_is_write, r_addr, r_wr_data);
                        w_state_next   = ST_SEND;
                    end else begin
                        if (!r_is_write) begin
                            w_rd_data_next = spi_rx_byte;
                        end
                        w_state_next = ST_FINISH;
                    end
                end else begin
                    // Abort once the count reaches its last value, so error
                    // fires TIMEOUT_CYCLES cycles after spi_start and the
                    // counter can never wrap.
                    w_tmo_next = w_tmo_inc;
                    if (w_tmo_inc == TMO_LAST) begin
                        w_state_next = ST_ABORT;
                    end
                end
            end

            ST_FINISH: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end

            ST_ABORT: begin
                busy         = 1'b1;
                error        = 1'b1;
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adxl362_controller.sv
// ---------------------------------------------------------------------------
// tb_adxl362_controller
// Drives the controller against a behavioural byte-level SPI master plus a
// tiny ADXL362 register file, and checks frames, handshakes and timeouts.
// ---------------------------------------------------------------------------
module tb_adxl362_controller;

    localparam int T_CYC    = 64;   // reduced TIMEOUT_CYCLES for a short run
    localparam int BYTE_CYC = 8;    // cycles one SPI byte takes in the model
    localparam int LIMIT    = 500;  // bound on any wait for a DUT event

    logic       clk = 1'b0;
    logic       rst;
    logic       start_read, start_write;
    logic [7:0] addr, wr_data;
    logic       busy, done, error;
    logic [7:0] rd_data;
    logic       spi_start;
    logic [7:0] spi_tx_byte;
    logic       spi_hold_cs;
    logic       spi_busy, spi_done;
    logic [7:0] spi_rx_byte;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adxl362_controller #(.TIMEOUT_CYCLES(T_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_read  (start_read),
        .start_write (start_write),
        .addr        (addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .rd_data     (rd_data),
        .spi_start   (spi_start),
        .spi_tx_byte (spi_tx_byte),
        .spi_hold_cs (spi_hold_cs),
        .spi_busy    (spi_busy),
        .spi_done    (spi_done),
        .spi_rx_byte (spi_rx_byte)
    );

    // ---------------- behavioural SPI master + sensor registers ------------
    logic [7:0] mem [0:255];
    logic [7:0] tx_log [$];
    logic       hold_log [$];
    logic       kill_done = 1'b0;
    logic       m_active;
    int         m_cnt;
    int         m_pos;
    logic [7:0] m_cmd, m_addr, m_rx;

    always @(posedge clk) begin
        spi_done <= 1'b0;
        if (rst) begin
            spi_busy    <= 1'b0;
            spi_rx_byte <= 8'h00;
            m_active    <= 1'b0;
            m_cnt       <= 0;
            m_pos       <= 0;
            m_cmd       <= 8'h00;
            m_addr      <= 8'h00;
            m_rx        <= 8'h00;
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h00] <= 8'hAD;
            mem[8'h02] <= 8'hF2;
        end else if (m_active) begin
            if (m_cnt == BYTE_CYC - 1) begin
                m_active    <= 1'b0;
                spi_busy    <= 1'b0;
                spi_done    <= !kill_done;
                spi_rx_byte <= m_rx;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (spi_start) begin
            tx_log.push_back(spi_tx_byte);
            hold_log.push_back(spi_hold_cs);
            m_active <= 1'b1;
            spi_busy <= 1'b1;
            m_cnt    <= 0;
            m_rx     <= 8'h00;
            if (m_pos == 0) m_cmd  <= spi_tx_byte;
            if (m_pos == 1) m_addr <= spi_tx_byte;
            if (m_pos == 2) begin
                if (m_cmd == 8'h0B) m_rx <= mem[m_addr];
                if (m_cmd == 8'h0A) mem[m_addr] <= spi_tx_byte;
            end
            m_pos <= spi_hold_cs ? m_pos + 1 : 0;
        end
    end

    // Event counters for done/error/spi_done pulses
    int done_cnt = 0, err_cnt = 0, sd_cnt = 0;
    always @(posedge clk) if (done)     done_cnt++;
    always @(posedge clk) if (error)    err_cnt++;
    always @(posedge clk) if (spi_done) sd_cnt++;

    // ---------------- checking helpers ------------------------------------
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse a request for one cycle; returns at the negedge after acceptance.
    task automatic issue(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        start_read  = rd;
        start_write = wr;
        addr        = a;
        wr_data     = d;
        @(negedge clk);
        start_read  = 1'b0;
        start_write = 1'b0;
    endtask

    // Step negedges until done or error is seen (bounded).
    task automatic wait_end(output int n);
        n = 0;
        while (!done && !error && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) begin
            failures++;
            checks++;
            $display("FAIL wait_end: no done/error within %0d cycles", LIMIT);
        end
    endtask

    // Compare the three bytes logged from index base against a frame.
    task automatic check_frame(input string tag, input int base,
                               input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] exp_b [3];
        logic       exp_h [3];
        exp_b = '{b0, b1, b2};
        exp_h = '{1'b1, 1'b1, 1'b0};
        check({tag, "_nbytes"}, 16'(tx_log.size() - base), 16'd3);
        for (int i = 0; i < 3; i++) begin
            if (base + i < tx_log.size()) begin
                check($sformatf("%s_mosi%0d", tag, i), {8'h00, tx_log[base+i]}, {8'h00, exp_b[i]});
                check($sformatf("%s_cs%0d", tag, i), {15'h0, hold_log[base+i]}, {15'h0, exp_h[i]});
            end
        end
    endtask

    // ---------------- stimulus --------------------------------------------
    initial begin
        int n, base, d0, e0, sd0, waited;
        rst = 1'b1; start_read = 1'b0; start_write = 1'b0; addr = 8'h00; wr_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy",   {15'h0, busy},        16'h0);
        check("rst_done",   {15'h0, done},        16'h0);
        check("rst_error",  {15'h0, error},       16'h0);
        check("rst_start",  {15'h0, spi_start},   16'h0);
        check("rst_hold",   {15'h0, spi_hold_cs}, 16'h0);
        check("rst_rd",     {8'h0, rd_data},      16'h0);
        check("rst_tx",     {8'h0, spi_tx_byte},  16'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: read DEVID_AD
        base = tx_log.size(); d0 = done_cnt;
        issue(1'b1, 1'b0, 8'h00, 8'h00);
        check("t1_busy_accept", {15'h0, busy},      16'h1);
        check("t1_first_start", {15'h0, spi_start}, 16'h1);
        wait_end(n);
        check("t1_done",      {15'h0, done},  16'h1);
        check("t1_rd",        {8'h0, rd_data}, 16'h00AD);
        @(negedge clk);
        check("t1_done_once", 16'(done_cnt - d0), 16'd1);
        check_frame("t1", base, 8'h0B, 8'h00, 8'h00);

        // 2: read PARTID, busy window
        issue(1'b1, 1'b0, 8'h02, 8'h00);
        check("t2_busy_accept", {15'h0, busy}, 16'h1);
        wait_end(n);
        check("t2_busy_at_done", {15'h0, busy}, 16'h1);
        check("t2_rd",           {8'h0, rd_data}, 16'h00F2);
        @(negedge clk);
        check("t2_busy_after",   {15'h0, busy}, 16'h0);
        check("t2_done_after",   {15'h0, done}, 16'h0);

        // 3: soft-reset write; a read request while busy is ignored
        base = tx_log.size(); d0 = done_cnt;
        issue(1'b0, 1'b1, 8'h1F, 8'h52);
        issue(1'b1, 1'b0, 8'h00, 8'h00);
        wait_end(n);
        check("t3_done", {15'h0, done},   16'h1);
        check("t3_rd",   {8'h0, rd_data}, 16'h00F2);
        repeat (BYTE_CYC * 4) @(negedge clk);
        check("t3_done_once", 16'(done_cnt - d0), 16'd1);
        check_frame("t3", base, 8'h0A, 8'h1F, 8'h52);

        // 4: read and write together -> write only
        base = tx_log.size();
        issue(1'b1, 1'b1, 8'h2D, 8'h02);
        wait_end(n);
        check("t4_done", {15'h0, done}, 16'h1);
        repeat (BYTE_CYC * 4) @(negedge clk);
        check_frame("t4", base, 8'h0A, 8'h2D, 8'h02);

        // 5: spi_done never arrives -> timeout abort
        kill_done = 1'b1; d0 = done_cnt; e0 = err_cnt;
        issue(1'b1, 1'b0, 8'h00, 8'h00);
        check("t5_start", {15'h0, spi_start}, 16'h1);
        wait_end(n);
        check("t5_error",      {15'h0, error},       16'h1);
        check("t5_latency",    16'(n),               16'(T_CYC));
        check("t5_cs_release", {15'h0, spi_hold_cs}, 16'h0);
        check("t5_rd_kept",    {8'h0, rd_data},      16'h00F2);
        @(negedge clk);
        check("t5_err_once", 16'(err_cnt - e0),  16'd1);
        check("t5_no_done",  16'(done_cnt - d0), 16'd0);
        kill_done = 1'b0;
        repeat (BYTE_CYC * 2) @(negedge clk);

        // 6: reset after the second byte
        sd0 = sd_cnt; d0 = done_cnt; e0 = err_cnt;
        issue(1'b1, 1'b0, 8'h00, 8'h00);
        waited = 0;
        while (sd_cnt < sd0 + 2 && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        check("t6_reached_byte2", {15'h0, sd_cnt >= sd0 + 2}, 16'h1);
        rst = 1'b1;
        #1;
        check("t6_busy",  {15'h0, busy},        16'h0);
        check("t6_start", {15'h0, spi_start},   16'h0);
        check("t6_hold",  {15'h0, spi_hold_cs}, 16'h0);
        check("t6_tx",    {8'h0, spi_tx_byte},  16'h0);
        check("t6_rd",    {8'h0, rd_data},      16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_no_done",  16'(done_cnt - d0), 16'd0);
        check("t6_no_error", 16'(err_cnt - e0),  16'd0);
        issue(1'b1, 1'b0, 8'h00, 8'h00);
        wait_end(n);
        check("t6_reread", {8'h0, rd_data}, 16'h00AD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
